// File: rtl/ctl_status_writer_if.sv
// Controller BRAM write-port bundle: request/grant arbitration plus write strobe, address, data.
interface ctl_status_writer_if #(
  parameter int unsigned ADDR_WIDTH = 14
) ();
  logic                  BRAM_REQ;
  logic                  BRAM_GNT;
  logic                  BRAM_WE;
  logic [ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [15:0]           BRAM_DIN;

  modport master (
    output BRAM_REQ,
    output BRAM_WE,
    output BRAM_ADDR,
    output BRAM_DIN,
    input  BRAM_GNT
  );

  modport slave (
    input  BRAM_REQ,
    input  BRAM_WE,
    input  BRAM_ADDR,
    input  BRAM_DIN,
    output BRAM_GNT
  );
endinterface

// File: rtl/ctl_status_writer.sv
// Status write-back: snapshots runtime status and writes a 4-word frame into the controller
// BRAM region, periodically and whenever the state word changes.
module ctl_status_writer #(
  parameter int unsigned           ADDR_WIDTH     = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0100,
  parameter int unsigned           REFRESH_CYCLES = 20480
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       ENABLE,
  input  logic                       THERMO,
  input  logic                       FORCE_FAN,
  input  logic                       MOD_SEGMENT,
  input  logic                       STM_SEGMENT,
  input  logic                       STM_MODE,
  input  logic [14:0]                MOD_IDX,
  input  logic [15:0]                STM_IDX,
  ctl_status_writer_if.master        bram,
  output logic                       BUSY,
  output logic                       FRAME_DONE
);

  typedef enum logic [2:0] {StIdle, StSnap, StReq, StWrite, StDone} state_e;

  localparam logic [23:0] CntMax = 24'(REFRESH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [23:0]           cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [15:0]           seq_q, seq_d;
  logic [4:0]            last_s_q, last_s_d;
  logic [4:0]            snap_s_q, snap_s_d;
  logic [14:0]           snap_mod_q, snap_mod_d;
  logic [15:0]           snap_stm_q, snap_stm_d;
  logic [1:0]            k_q, k_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4:0]            live_s;
  logic [4:0]            cmp_s;
  logic                  trigger;

  assign live_s  = {STM_MODE, STM_SEGMENT, MOD_SEGMENT, FORCE_FAN, THERMO};
  assign trigger = (state_q == StIdle) && ENABLE && ((cnt_q == CntMax) || pend_q);

  // Frame word k, built only from the snapshot registers.
  function automatic logic [15:0] frame_word(input logic [1:0] k);
    unique case (k)
      2'd0:    frame_word = {11'd0, snap_s_q};
      2'd1:    frame_word = {1'b0, snap_mod_q};
      2'd2:    frame_word = snap_stm_q;
      default: frame_word = seq_q;
    endcase
  endfunction

  // Next-state logic for the frame FSM, change detection and refresh counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + 24'd1;
    pend_d     = pend_q;
    seq_d      = seq_q;
    last_s_d   = last_s_q;
    snap_s_d   = snap_s_q;
    snap_mod_d = snap_mod_q;
    snap_stm_d = snap_stm_q;
    k_d        = k_q;
    req_d      = req_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // While a frame is in flight, compare against the frame being written so the frame's own
    // state word does not re-arm a change; it equals last_s once the frame completes.
    cmp_s = (state_q == StIdle) ? last_s_q : snap_s_q;
    if (live_s != cmp_s) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (done_q) busy_d = 1'b0;
        if (trigger) begin
          state_d = StSnap;
          cnt_d   = '0;
        end
      end
      StSnap: begin
        snap_s_d   = live_s;
        snap_mod_d = MOD_IDX;
        snap_stm_d = STM_IDX;
        seq_d      = seq_q + 16'd1;
        pend_d     = 1'b0;
        busy_d     = 1'b1;
        req_d      = 1'b1;
        k_d        = 2'd0;
        state_d    = StReq;
      end
      StReq: begin
        if (bram.BRAM_GNT) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR;
          din_d   = frame_word(2'd0);
          k_d     = 2'd1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // A dropped grant simply holds k; the request stays up.
        if (bram.BRAM_GNT) begin
          we_d   = 1'b1;
          addr_d = BASE_ADDR + ADDR_WIDTH'(k_q);
          din_d  = frame_word(k_q);
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) state_d = StDone;
        end
      end
      StDone: begin
        done_d   = 1'b1;
        req_d    = 1'b0;
        last_s_d = snap_s_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      seq_q      <= '0;
      last_s_q   <= '0;
      snap_s_q   <= '0;
      snap_mod_q <= '0;
      snap_stm_q <= '0;
      k_q        <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      seq_q      <= seq_d;
      last_s_q   <= last_s_d;
      snap_s_q   <= snap_s_d;
      snap_mod_q <= snap_mod_d;
      snap_stm_q <= snap_stm_d;
      k_q        <= k_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bram.BRAM_REQ  = req_q;
  assign bram.BRAM_WE   = we_q;
  assign bram.BRAM_ADDR = addr_q;
  assign bram.BRAM_DIN  = din_q;
  assign BUSY           = busy_q;
  assign FRAME_DONE     = done_q;

endmodule
